auth_cmd_tx: RTL and testbench
==============================

# auth_cmd_tx

Transmit-side counterpart of the Segway authorization link. Serializes single-byte authorization commands, 'G' (0x47, power up) and 'S' (0x53, stop request), onto a UART line: 8N1, LSB first. It sits in the BLE/phone-emulation side of the system and in the top-level bench, and it drives the RX pin of the Segway's authorization block. It holds at most one pending command while a frame is in flight.

## Interface
- BAUD_DIV, default 5208: clock cycles per bit (50 MHz / 9600 baud); legal range 4..65535.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- go_req  in  1  one-cycle request to send 'G'.
- stop_req  in  1  one-cycle request to send 'S'.
- TX  out  1  UART serial output, idle high.
- busy  out  1  high while a frame is being shifted out.
- pending  out  1  high while one command is queued behind the current frame.
- cmd_done  out  1  one-cycle pulse after the stop bit of each frame completes.

## Operation
- Reset values: TX=1, busy=0, pending=0, cmd_done=0, state=IDLE, all counters 0.
- Request resolution: if go_req and stop_req are both high in the same cycle, stop_req wins ('S'). The 'G' is discarded.
- Idle launch: a request seen in IDLE loads the shift register and enters START. It is never queued.
- Request while busy: the command is latched into a one-deep pending slot and pending=1.
  - A later request overwrites the slot (last wins), except that a queued 'S' is never overwritten by 'G'.
- Frame end with pending=1: the queued byte starts immediately and pending clears. cmd_done still pulses for the finished frame.
- FSM states:
  - IDLE: TX=1.
  - START: TX=0 for BAUD_DIV cycles.
  - DATA: bits 0..7 LSB first, BAUD_DIV cycles each.
  - STOP: TX=1 for BAUD_DIV cycles.
  - After STOP the FSM goes to IDLE, or to START if a command is pending.
- Counters:
  - baud_cnt is 16-bit and counts 0..BAUD_DIV-1. Terminal count advances the bit.
  - bit_cnt is 3-bit, 0..7. Terminal count in DATA moves to STOP.
- TX is driven from a flop; it is never a combinational output.
- Reset mid-frame: on the next edge TX=1, busy=0, pending cleared, queued command dropped. No partial frame resumes.

## Timing
- A request sampled at edge N produces TX=0 (start bit) and busy=1 from edge N+1.
- Frame length is exactly 10*BAUD_DIV cycles: TX falls at edge N+1 and the stop bit ends at edge N+1+10*BAUD_DIV.
- cmd_done is high for the one cycle following the last stop-bit cycle. busy drops in that same cycle unless a pending frame starts.
- Back-to-back frames: the next start bit begins in the cycle immediately after the stop bit. There are 0 idle cycles and busy stays high.
- A request arriving in the same cycle as cmd_done counts as a busy-time request. It is queued for one cycle, then starts.

## Structure
- Shared package auth_pkg:
  - AUTH_CODE_GO = 8'h47 and AUTH_CODE_STOP = 8'h53, reused by the receive-side authorization block.
  - tx_state_t enum: IDLE, START, DATA, STOP.
- One sub-module, auth_uart_tx, holds the generic 8N1 shifter (baud counter, bit counter, FSM) with a load/byte/busy/done interface.
- auth_cmd_tx holds request arbitration, the pending slot and code selection.

## Test plan
All scenarios use BAUD_DIV=16.
- Single go: go_req pulse at cycle 10. TX low in cycles 11–26, then bits 1,1,1,0,0,0,1,0, then high in cycles 155–170. cmd_done at cycle 171.
- Simultaneous requests: go_req=stop_req=1 in one cycle. The frame decodes as 0x53; no 'G' follows.
- Queueing: stop_req during a 'G' frame. pending=1, and 'S' starts the cycle after the 'G' stop bit with busy continuously high. cmd_done pulses twice.
- Overwrite priority: during a busy frame, send go then stop, then go. The queued byte is 0x53.
- Reset mid-frame: rst asserted during DATA bit 3 with a pending command. TX=1, busy=0 and pending=0 on the next edge, and no further frames appear.
- Loopback: TX connected to the receive-side authorization block. 'G' then pwr_up=1; 'S' with rider_off=1 then pwr_up=0.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared definitions for the authorization link: command codes and the
// 8N1 transmitter state encoding, used by both the TX and RX sides.
package auth_pkg;

  localparam logic [7:0] AUTH_CODE_GO   = 8'h47;  // 'G' power up
  localparam logic [7:0] AUTH_CODE_STOP = 8'h53;  // 'S' stop request

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [7:0] auth_code(input logic is_stop);
    return is_stop ? AUTH_CODE_STOP : AUTH_CODE_GO;
  endfunction

endpackage

// File: rtl/auth_cmd_tx_if.sv
// Request/status bundle between a command source and auth_cmd_tx.
interface auth_cmd_tx_if;
  logic go_req;
  logic stop_req;
  logic TX;
  logic busy;
  logic pending;
  logic cmd_done;

  modport master (output go_req, stop_req, input TX, busy, pending, cmd_done);
  modport slave  (input go_req, stop_req, output TX, busy, pending, cmd_done);
endinterface

// File: rtl/auth_uart_tx.sv
// Generic 8N1 UART shifter, LSB first. A load is accepted in IDLE or in the
// last stop-bit cycle, so frames can run back to back with no idle gap.
module auth_uart_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       frame_end
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        baud_term;

  assign baud_term = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d = state_q;
    baud_d  = baud_term ? 16'd0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (load) begin
          state_d = START;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_term) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (baud_term) begin
          bit_d = bit_q + 3'd1;  // wraps back to 0 after bit 7
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (baud_term) begin
          done_d = 1'b1;
          if (load) begin
            state_d = START;
            shreg_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments; the shift register is reset too
  // so a frame cut short by rst leaves no stale data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign frame_end = (state_q == STOP) && baud_term;

endmodule

// File: rtl/auth_cmd_tx.sv
// Authorization command transmitter: arbitrates go/stop requests, keeps a
// one-deep pending slot, and feeds the selected code to the 8N1 shifter.
module auth_cmd_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic          clk,
  input  logic          rst,
  auth_cmd_tx_if.slave  bus
);

  logic pend_q, pend_d;
  logic pend_stop_q, pend_stop_d;
  logic req, launch, load, load_stop;
  logic uart_tx, uart_busy, uart_done, frame_end;

  always_comb begin
    req         = bus.go_req | bus.stop_req;
    pend_d      = pend_q;
    pend_stop_d = pend_stop_q;
    load        = 1'b0;
    load_stop   = pend_stop_q;
    launch      = 1'b0;

    // A queued command goes out as soon as the shifter can take it; a fresh
    // request only launches directly when the link is truly quiet, so one
    // arriving alongside cmd_done is treated as busy-time and queued.
    if (pend_q && (frame_end || !uart_busy)) begin
      load   = 1'b1;
      pend_d = 1'b0;
    end else if (req && !uart_busy && !uart_done) begin
      load      = 1'b1;
      load_stop = bus.stop_req;
      launch    = 1'b1;
    end

    // Last request wins the slot, but a queued stop is never displaced by a go.
    if (req && !launch && !(pend_d && pend_stop_d && !bus.stop_req)) begin
      pend_d      = 1'b1;
      pend_stop_d = bus.stop_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_stop_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_stop_q <= pend_stop_d;
    end
  end

  auth_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (auth_code(load_stop)),
    .tx        (uart_tx),
    .busy      (uart_busy),
    .done      (uart_done),
    .frame_end (frame_end)
  );

  assign bus.TX       = uart_tx;
  assign bus.busy     = uart_busy;
  assign bus.pending  = pend_q;
  assign bus.cmd_done = uart_done;

endmodule

// File: tb/tb_auth_cmd_tx.sv
// Bench for auth_cmd_tx: directed scenarios with fixed timing points plus a
// randomized run, all checked every cycle against a frame-timing reference model.
module tb_auth_cmd_tx;

  localparam int B = 16;
  localparam int F = 10 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   model_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   k = 0;

  auth_cmd_tx_if bus ();

  auth_cmd_tx #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is just "cycles elapsed since its start bit",
  // lasting F cycles, plus a one-entry pending slot.
  bit       m_act, m_pend, m_ps, m_done;
  int       m_el;
  bit [7:0] m_byte;

  function automatic bit model_tx();
    if (!m_act)        return 1'b1;
    if (m_el < B)      return 1'b0;
    if (m_el < 9 * B)  return m_byte[m_el / B - 1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit req, fe, took;
    if (rst) begin
      m_act = 0; m_el = 0; m_pend = 0; m_ps = 0; m_done = 0; m_byte = 8'h00;
    end else begin
      req  = bus.go_req | bus.stop_req;
      fe   = m_act && (m_el == F - 1);
      took = 0;
      if (fe) begin
        if (m_pend) begin
          m_el = 0; m_byte = m_ps ? 8'h53 : 8'h47; m_pend = 0;
        end else begin
          m_act = 0;
        end
      end else if (m_act) begin
        m_el++;
      end else if (m_pend) begin
        m_act = 1; m_el = 0; m_byte = m_ps ? 8'h53 : 8'h47; m_pend = 0;
      end else if (req && !m_done) begin
        m_act = 1; m_el = 0; m_byte = bus.stop_req ? 8'h53 : 8'h47; took = 1;
      end
      if (req && !took && !(m_pend && m_ps && !bus.stop_req)) begin
        m_pend = 1; m_ps = bus.stop_req;
      end
      m_done = fe;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      check("cyc_tx",      32'(bus.TX),       32'(model_tx()));
      check("cyc_busy",    32'(bus.busy),     32'(m_act));
      check("cyc_pending", 32'(bus.pending),  32'(m_pend));
      check("cyc_done",    32'(bus.cmd_done), 32'(m_done));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to(input int t);
    adv(t - k);
    k = t;
  endtask

  task automatic pulse(input bit g, input bit s);
    bus.go_req   = g;
    bus.stop_req = s;
    @(negedge clk);
    bus.go_req   = 1'b0;
    bus.stop_req = 1'b0;
    k++;
  endtask

  initial begin
    bus.go_req   = 1'b0;
    bus.stop_req = 1'b0;
    rst          = 1'b1;
    adv(3);
    check("rst_tx",      32'(bus.TX),       32'd1);
    check("rst_busy",    32'(bus.busy),     32'd0);
    check("rst_pending", 32'(bus.pending),  32'd0);
    check("rst_done",    32'(bus.cmd_done), 32'd0);
    model_en = 1'b1;
    rst      = 1'b0;
    adv(5);

    // Single go: 0x47 = bits 1,1,1,0,0,0,1,0 LSB first
    k = 0; pulse(1, 0);
    check("go_start_tx",  32'(bus.TX),   32'd0);
    check("go_busy",      32'(bus.busy), 32'd1);
    to(16);  check("go_start_end", 32'(bus.TX), 32'd0);
    to(17);  check("go_bit0",      32'(bus.TX), 32'd1);
    to(65);  check("go_bit3",      32'(bus.TX), 32'd0);
    to(113); check("go_bit6",      32'(bus.TX), 32'd1);
    to(144); check("go_bit7",      32'(bus.TX), 32'd0);
    to(145); check("go_stop_tx",   32'(bus.TX), 32'd1);
    to(160); check("go_last_done", 32'(bus.cmd_done), 32'd0);
    check("go_last_busy", 32'(bus.busy), 32'd1);
    to(161); check("go_done",      32'(bus.cmd_done), 32'd1);
    check("go_done_busy", 32'(bus.busy), 32'd0);
    to(162); check("go_done_end",  32'(bus.cmd_done), 32'd0);
    to(170);

    // Simultaneous go+stop: stop wins, nothing queued
    k = 0; pulse(1, 1);
    to(2);   check("sim_pending", 32'(bus.pending), 32'd0);
    to(17);  check("sim_bit0",    32'(bus.TX), 32'd1);
    to(49);  check("sim_bit2",    32'(bus.TX), 32'd0);
    to(161); check("sim_done",    32'(bus.cmd_done), 32'd1);
    to(200); check("sim_no_more", 32'(bus.busy), 32'd0);

    // Queueing: stop during a go frame, back to back
    k = 0; pulse(1, 0);
    to(50); pulse(0, 1);
    check("q_pending",     32'(bus.pending), 32'd1);
    to(161); check("q_done1",   32'(bus.cmd_done), 32'd1);
    check("q_b2b_busy",    32'(bus.busy), 32'd1);
    check("q_b2b_tx",      32'(bus.TX),   32'd0);
    check("q_pend_clear",  32'(bus.pending), 32'd0);
    to(321); check("q_done2",   32'(bus.cmd_done), 32'd1);
    to(330);

    // Overwrite priority: go, stop, go while busy -> stop stays queued
    k = 0; pulse(1, 0);
    to(30); pulse(1, 0);
    to(40); pulse(0, 1);
    to(50); pulse(1, 0);
    check("ow_pending", 32'(bus.pending), 32'd1);
    to(177); check("ow_bit0", 32'(bus.TX), 32'd1);
    to(209); check("ow_bit2", 32'(bus.TX), 32'd0);
    to(340);

    // Request in the cmd_done cycle: queued one cycle, then starts
    k = 0; pulse(1, 0);
    to(161); check("dc_done", 32'(bus.cmd_done), 32'd1);
    pulse(0, 1);
    check("dc_pending", 32'(bus.pending), 32'd1);
    check("dc_idle",    32'(bus.busy),    32'd0);
    to(163); check("dc_start", 32'(bus.TX), 32'd0);
    check("dc_busy",    32'(bus.busy),    32'd1);
    to(330);

    // Reset mid-frame during data bit 3 with a command pending
    k = 0; pulse(1, 0);
    to(20); pulse(0, 1);
    to(70); check("rm_pending_pre", 32'(bus.pending), 32'd1);
    rst = 1'b1; adv(1); rst = 1'b0; k = 71;
    check("rm_tx",      32'(bus.TX),      32'd1);
    check("rm_busy",    32'(bus.busy),    32'd0);
    check("rm_pending", 32'(bus.pending), 32'd0);
    to(400); check("rm_quiet", 32'(bus.busy), 32'd0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus.go_req   = (r < 4);
      bus.stop_req = (r >= 3) && (r < 6);
      rst          = ($urandom_range(0, 1999) == 0);
      @(negedge clk);
    end
    bus.go_req   = 1'b0;
    bus.stop_req = 1'b0;
    rst          = 1'b0;
    adv(2 * F + 10);
    check("end_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
